// File: rtl/ccff_bitstream_loader_if.sv
// Host-side bundle for the configuration-chain loader: load control, word stream
// into the loader, and readback words coming back out.
interface ccff_bitstream_loader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] rb_data;
  logic                  rb_valid;

  modport master (
    output start, in_data, in_valid,
    input  in_ready, rb_data, rb_valid
  );

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, rb_data, rb_valid
  );
endinterface

// File: rtl/ccff_bitstream_loader.sv
// Serializes host words MSB-first into the configuration chain, gating the chain
// clock one bit per cycle, and gathers the bits falling out of the tail into readback words.
module ccff_bitstream_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int CHAIN_LEN  = 4096,
  parameter int CNT_W      = $clog2(CHAIN_LEN+1)
) (
  input  logic                 prog_clk,
  input  logic                 prog_reset_n,
  ccff_bitstream_loader_if.slave host,
  output logic                 ccff_head,
  output logic                 prog_clk_en,
  input  logic                 ccff_tail,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     bits_shifted
);
  localparam int IDX_W = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      bits_q, bits_d;
  logic [DATA_WIDTH-1:0] rbsh_q, rbsh_d;
  logic [IDX_W-1:0]      rbcnt_q, rbcnt_d;
  logic [DATA_WIDTH-1:0] rbdata_q, rbdata_d;
  logic                  rbvalid_q, rbvalid_d;
  logic                  head_q, head_d;
  logic                  pce_q, pce_d;
  logic                  rdy_q, rdy_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] rb_word;
  logic                  hs, final_bit, word_end;

  assign hs        = host.in_valid & rdy_q;
  assign final_bit = (bits_q == CNT_W'(CHAIN_LEN-1));
  assign word_end  = (idx_q == '0);

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    idx_d     = idx_q;
    bits_d    = bits_q;
    rbsh_d    = rbsh_q;
    rbcnt_d   = rbcnt_q;
    rbdata_d  = rbdata_q;
    rbvalid_d = 1'b0;
    rb_word   = {rbsh_q[DATA_WIDTH-2:0], ccff_tail};
    case (state_q)
      IDLE, DONE: begin
        if (host.start) begin
          state_d = LOAD;
          bits_d  = '0;
          rbsh_d  = '0;
          rbcnt_d = '0;
        end
      end
      LOAD: begin
        if (hs) begin
          sreg_d  = host.in_data;
          idx_d   = IDX_W'(DATA_WIDTH-1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bits_d = bits_q + 1'b1;
        sreg_d = sreg_q << 1;
        idx_d  = idx_q - 1'b1;
        rbsh_d = rb_word;
        // A partial readback word at the end is left-justified so its first tail bit sits in the MSB.
        if (rbcnt_q == IDX_W'(DATA_WIDTH-1) || final_bit) begin
          rbdata_d  = rb_word << (IDX_W'(DATA_WIDTH-1) - rbcnt_q);
          rbvalid_d = 1'b1;
          rbcnt_d   = '0;
        end else begin
          rbcnt_d = rbcnt_q + 1'b1;
        end
        if (final_bit) begin
          state_d = DONE;
        end else if (word_end) begin
          if (hs) begin
            sreg_d = host.in_data;
            idx_d  = IDX_W'(DATA_WIDTH-1);
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from next state so they are flop outputs during the cycle they describe.
    pce_d  = (state_d == SHIFT);
    head_d = (state_d == SHIFT) & sreg_d[DATA_WIDTH-1];
    rdy_d  = (state_d == LOAD) ||
             ((state_d == SHIFT) && (idx_d == '0) && (bits_d != CNT_W'(CHAIN_LEN-1)));
    busy_d = (state_d == LOAD) || (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      idx_q     <= '0;
      bits_q    <= '0;
      rbsh_q    <= '0;
      rbcnt_q   <= '0;
      rbdata_q  <= '0;
      rbvalid_q <= 1'b0;
      head_q    <= 1'b0;
      pce_q     <= 1'b0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      idx_q     <= idx_d;
      bits_q    <= bits_d;
      rbsh_q    <= rbsh_d;
      rbcnt_q   <= rbcnt_d;
      rbdata_q  <= rbdata_d;
      rbvalid_q <= rbvalid_d;
      head_q    <= head_d;
      pce_q     <= pce_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign host.in_ready = rdy_q;
  assign host.rb_data  = rbdata_q;
  assign host.rb_valid = rbvalid_q;
  assign ccff_head     = head_q;
  assign prog_clk_en   = pce_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign bits_shifted  = bits_q;
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Three loaders (chains of 8, 12 and 16 flops) each driving a behavioural chain;
// loads are checked against a word/bit-stream model of what the chain should hold.
module tb_ccff_bitstream_loader;
  localparam int NI = 3;

  logic prog_clk = 1'b0;
  logic prog_reset_n;
  logic [NI-1:0]       start_a, val_a, pre_a, rdy_a, head_a, pce_a, rbv_a, busy_a, done_a;
  logic [NI-1:0][7:0]  dat_a, rbd_a;
  logic [NI-1:0][15:0] prev_a, chn_a;
  logic [NI-1:0][4:0]  bs_a;
  int checks = 0;
  int errors = 0;
  int wds[4];
  int gaps[4];

  always #5 prog_clk = ~prog_clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int CL = 8 + 4*gi;
    localparam int CW = $clog2(CL+1);
    logic [CW-1:0] bs;
    logic [CL-1:0] chain;
    ccff_bitstream_loader_if #(.DATA_WIDTH(8)) bus ();
    assign bus.start    = start_a[gi];
    assign bus.in_valid = val_a[gi];
    assign bus.in_data  = dat_a[gi];
    assign rdy_a[gi]    = bus.in_ready;
    assign rbv_a[gi]    = bus.rb_valid;
    assign rbd_a[gi]    = bus.rb_data;
    assign bs_a[gi]     = 5'(bs);
    assign chn_a[gi]    = 16'(chain);
    ccff_bitstream_loader #(.DATA_WIDTH(8), .CHAIN_LEN(CL)) u_dut (
      .prog_clk     (prog_clk),
      .prog_reset_n (prog_reset_n),
      .host         (bus),
      .ccff_head    (head_a[gi]),
      .prog_clk_en  (pce_a[gi]),
      .ccff_tail    (chain[CL-1]),
      .busy         (busy_a[gi]),
      .done         (done_a[gi]),
      .bits_shifted (bs)
    );
    always @(posedge prog_clk) begin
      if (pre_a[gi]) chain <= prev_a[gi][CL-1:0];
      else if (pce_a[gi]) chain <= {chain[CL-2:0], head_a[gi]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input int d);
    chk("rst_head", head_a[d], 0);
    chk("rst_pce", pce_a[d], 0);
    chk("rst_rdy", rdy_a[d], 0);
    chk("rst_rbdata", rbd_a[d], 0);
    chk("rst_rbvalid", rbv_a[d], 0);
    chk("rst_busy", busy_a[d], 0);
    chk("rst_done", done_a[d], 0);
    chk("rst_bits", bs_a[d], 0);
  endtask

  // One complete load on loader d; words/gaps come from wds/gaps (gap = in_ready cycles held off).
  task automatic do_load(input int d, input logic [15:0] pre, input int start_at, input int abort_at);
    int cl, need, en, stall, wi, gcnt, exp_stall, idx;
    logic [15:0] obs_head, exp_head;
    logic [7:0] rbq[$];
    logic [7:0] w, ew;
    logic prev_pce;
    bit fin;
    cl = 8 + 4*d; need = (cl + 7) / 8;
    en = 0; stall = 0; wi = 0; gcnt = gaps[0];
    obs_head = '0; exp_head = '0; prev_pce = 1'b0; fin = 0;
    @(negedge prog_clk);
    prev_a[d] = pre; pre_a[d] = 1'b1; start_a[d] = 1'b1; val_a[d] = 1'b0;
    @(negedge prog_clk);
    pre_a[d] = 1'b0; start_a[d] = 1'b0;
    chk("start_busy", busy_a[d], 1);
    chk("start_done_clr", done_a[d], 0);
    chk("start_bits_clr", bs_a[d], 0);
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      if (rbv_a[d]) rbq.push_back(rbd_a[d]);
      if (done_a[d]) begin
        fin = 1;
        chk("done_timing", prev_pce, 1);
      end else begin
        start_a[d] = 1'b0;
        if (pce_a[d]) begin
          en++;
          obs_head = {obs_head[14:0], head_a[d]};
          chk("bits_run", bs_a[d], en - 1);
          chk("rdy_in_shift", rdy_a[d], (en % 8 == 0 && en < cl) ? 1 : 0);
          start_a[d] = (en == start_at);
        end else if (en > 0) begin
          stall++;
        end
        prev_pce = pce_a[d];
        if (abort_at > 0 && en == abort_at) begin
          prog_reset_n = 1'b0; val_a[d] = 1'b0; start_a[d] = 1'b0;
          @(negedge prog_clk);
          check_zero(d);
          prog_reset_n = 1'b1;
          return;
        end
        if (rdy_a[d] && wi < need) begin
          if (gcnt > 0) begin
            gcnt--; val_a[d] = 1'b0;
          end else begin
            val_a[d] = 1'b1; dat_a[d] = 8'(wds[wi]);
            wi++; gcnt = (wi < 4) ? gaps[wi] : 0;
          end
        end else begin
          val_a[d] = rdy_a[d] ? 1'b0 : 1'($urandom_range(0, 1));
          dat_a[d] = 8'($urandom);
        end
        @(negedge prog_clk);
      end
    end
    val_a[d] = 1'b0; start_a[d] = 1'b0;
    chk("done_seen", fin, 1);
    if (fin) begin
      chk("final_bits", bs_a[d], cl);
      chk("final_busy", busy_a[d], 0);
      chk("final_rdy", rdy_a[d], 0);
      chk("final_pce", pce_a[d], 0);
      chk("final_head", head_a[d], 0);
      chk("en_count", en, cl);
      exp_stall = 0;
      for (int k = 1; k < need; k++) exp_stall += gaps[k];
      chk("stall_cycles", stall, exp_stall);
      for (int j = 0; j < cl; j++) begin
        w = 8'(wds[j / 8]);
        exp_head = {exp_head[14:0], w[7 - (j % 8)]};
      end
      chk("head_stream", obs_head, exp_head);
      chk("chain_contents", chn_a[d], exp_head);
      chk("rb_count", rbq.size(), need);
      for (int k = 0; k < need && k < rbq.size(); k++) begin
        ew = '0;
        for (int b = 0; b < 8; b++) begin
          idx = k*8 + b;
          if (idx < cl) ew[7 - b] = pre[cl - 1 - idx];
        end
        chk("rb_word", rbq[k], ew);
      end
      @(negedge prog_clk);
      chk("rb_pulse_width", rbv_a[d], 0);
      chk("done_hold", done_a[d], 1);
    end
  endtask

  initial begin
    int d;
    prog_reset_n = 1'b0;
    start_a = '0; val_a = '0; pre_a = '0; dat_a = '0; prev_a = '0;
    repeat (3) @(negedge prog_clk);
    for (int i = 0; i < NI; i++) check_zero(i);
    prog_reset_n = 1'b1;

    // single word into an 8-flop chain holding 0x5A
    wds[0] = 'hC3; gaps[0] = 0; gaps[1] = 0;
    do_load(0, 16'h005A, -1, -1);

    // 12-flop chain: partial second word, all-ones readback
    wds[0] = 'hAB; wds[1] = 'hCD; gaps[0] = 0; gaps[1] = 0;
    do_load(1, 16'h0FFF, -1, -1);

    // 16-flop chain, second word held off 3 cycles
    wds[0] = 'h96; wds[1] = 'h3E; gaps[0] = 0; gaps[1] = 3;
    do_load(2, 16'hA5C3, -1, -1);

    // back-to-back words with a stray start mid-shift
    wds[0] = 'h5B; wds[1] = 'hE1; gaps[0] = 0; gaps[1] = 0;
    do_load(2, 16'h1234, 5, -1);

    // reset after 5 bits, then a clean load from IDLE
    do_load(2, 16'hFFFF, -1, 5);
    wds[0] = 'h71; wds[1] = 'h8C; gaps[1] = 1;
    do_load(2, 16'hBEEF, -1, -1);

    for (int r = 0; r < 10; r++) begin
      d = $urandom_range(0, NI - 1);
      gaps[0] = 0;
      for (int k = 0; k < 4; k++) begin
        wds[k] = $urandom_range(0, 255);
        if (k > 0) gaps[k] = $urandom_range(0, 3);
      end
      do_load(d, 16'($urandom), $urandom_range(0, 20), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
